cabin_alarm_ctrl: RTL and testbench
===================================

CABIN_ALARM_CTRL -- requirements
Module: cabin_alarm_ctrl

Interface
REQ-001 Parameter SAMPLE_DIV, default 16, clk cycles per sample strobe; legal range 2..255.
REQ-002 Parameter T_LIMIT, default 5'd24, unsigned temperature threshold, inclusive.
REQ-003 Parameter HYST, default 5'd2, fan-release hysteresis; HYST <= T_LIMIT.
REQ-004 Parameter CONFIRM, default 3, consecutive qualifying samples to start fan; legal range 2..15.
REQ-005 Parameter ALARM_HOLD, default 8, qualifying samples in FAN before alarm; legal range 1..15.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 Temp  input  5  registered temperature from the upstream input register, unsigned.
REQ-009 Ca  input  1  registered ignition flag (1 = car on).
REQ-010 Pre  input  1  registered presence flag (1 = occupant detected).
REQ-011 EN  output  1  sample strobe driving the upstream input register enable.
REQ-012 fan  output  1  ventilation request.
REQ-013 alarm  output  1  alarm request.
REQ-014 state  output  2  current FSM state code.

Function
REQ-015 The free-running divider SHALL count 0..SAMPLE_DIV-1 and wrap; EN SHALL be registered and high for exactly 1 cycle per wrap.
REQ-016 The first EN pulse SHALL occur SAMPLE_DIV cycles after the first rising edge following rst release.
REQ-017 An internal eval flag SHALL be EN delayed by 1 cycle; the FSM SHALL update only on edges where eval=1, so inputs are sampled once the upstream register has latched them.
REQ-018 danger SHALL be (Ca==0) && (Pre==1) && (Temp >= T_LIMIT), using an unsigned 5-bit compare.
REQ-019 The release level SHALL be T_LIMIT-HYST, computed in 5 bits with no underflow given REQ-003.
REQ-020 The state codes SHALL be IDLE=00, WATCH=01, FAN=10, ALARM=11.
REQ-021 Priority on eval: Ca==1 SHALL force IDLE from any state and clear both counters.
REQ-022 IDLE: danger -> WATCH with the confirm counter set to 1; otherwise stay in IDLE.
REQ-023 WATCH: danger increments the confirm counter, and reaching CONFIRM -> FAN with both counters cleared; no danger -> IDLE with the confirm counter cleared.
REQ-024 FAN: danger increments the escalation counter, and reaching ALARM_HOLD -> ALARM.
REQ-025 FAN: Pre==0 or Temp < T_LIMIT-HYST -> IDLE with counters cleared.
REQ-026 FAN: Pre==1 with T_LIMIT-HYST <= Temp < T_LIMIT -> stay in FAN with the escalation counter held.
REQ-027 ALARM SHALL be latched and exited only on eval with Ca==1 or Pre==0 -> IDLE; a temperature drop SHALL NOT clear it.
REQ-028 The 4-bit counters SHALL saturate and never wrap.
REQ-029 fan SHALL be 1 in FAN and ALARM; alarm SHALL be 1 in ALARM only; all outputs SHALL be registered and decoded from state with no glitches.
REQ-030 Input changes between eval edges SHALL have no effect.

Reset
REQ-031 While rst=1: EN=0, fan=0, alarm=0, state=IDLE, divider=0, eval=0, all counters=0, immediately and independent of clk.
REQ-032 Asserting rst mid-operation, including in ALARM, SHALL abort all pending counts; no state is retained.

Verification
REQ-033 Reset, then hold rst=0 -> EN pulses 1 cycle every 16 cycles, first at cycle 16; fan=alarm=0.
REQ-034 Ca=0, Pre=1, Temp=25 constant -> WATCH after eval 1, FAN after eval 3, ALARM after eval 11.
REQ-035 Threshold boundary: Temp=23 -> remains IDLE indefinitely; Temp=24 -> WATCH at the next eval.
REQ-036 In WATCH after 2 evals, Temp=20 -> IDLE; the next danger sequence needs 3 fresh evals to reach FAN.
REQ-037 In FAN, Temp=23 -> stays FAN, escalation held; Temp=21 -> IDLE, fan=0.
REQ-038 In ALARM, Temp=10 -> alarm stays 1; then Ca=1 -> IDLE at next eval; rst asserted in ALARM -> alarm=0 asynchronously.

Source files
------------

// File: rtl/cabin_alarm_ctrl.sv
// cabin_alarm_ctrl: cabin overheat watchdog; strobes input sampling and escalates IDLE->WATCH->FAN->ALARM on sustained danger
module cabin_alarm_ctrl #(
  parameter int unsigned SAMPLE_DIV = 16,
  parameter logic [4:0]  T_LIMIT    = 5'd24,
  parameter logic [4:0]  HYST       = 5'd2,
  parameter int unsigned CONFIRM    = 3,
  parameter int unsigned ALARM_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Temp,
  input  logic       Ca,
  input  logic       Pre,
  output logic       EN,
  output logic       fan,
  output logic       alarm,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE = 2'b00, WATCH = 2'b01, FAN = 2'b10, ALARM = 2'b11} state_t;
  localparam logic [4:0] REL     = T_LIMIT - HYST;
  localparam logic [7:0] DIV_MAX = 8'(SAMPLE_DIV - 1);
  localparam logic [3:0] CONF_N  = 4'(CONFIRM);
  localparam logic [3:0] HOLD_N  = 4'(ALARM_HOLD);
  logic [7:0] div;
  logic       eval;
  state_t     cur, nxt;
  logic [3:0] conf, conf_n, esc, esc_n, conf_inc, esc_inc;
  logic       danger;
  // eval lags EN by one cycle so the upstream register has already latched the sample
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div  <= '0;
      EN   <= 1'b0;
      eval <= 1'b0;
    end else begin
      div  <= (div == DIV_MAX) ? '0 : div + 8'd1;
      EN   <= div == DIV_MAX;
      eval <= EN;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur  <= IDLE;
      conf <= '0;
      esc  <= '0;
    end else if (eval) begin
      cur  <= nxt;
      conf <= conf_n;
      esc  <= esc_n;
    end
  assign danger   = !Ca && Pre && (Temp >= T_LIMIT);
  assign conf_inc = (conf == 4'hf) ? conf : conf + 4'd1;
  assign esc_inc  = (esc == 4'hf) ? esc : esc + 4'd1;
  always_comb begin
    nxt    = cur;
    conf_n = conf;
    esc_n  = esc;
    if (Ca) begin
      nxt    = IDLE;
      conf_n = '0;
      esc_n  = '0;
    end else
      case (cur)
        IDLE:  if (danger) begin
                 nxt    = WATCH;
                 conf_n = 4'd1;
               end
        WATCH: if (!danger) begin
                 nxt    = IDLE;
                 conf_n = '0;
               end else if (conf_inc >= CONF_N) begin
                 nxt    = FAN;
                 conf_n = '0;
                 esc_n  = '0;
               end else
                 conf_n = conf_inc;
        FAN:   if (!Pre || Temp < REL) begin
                 nxt    = IDLE;
                 conf_n = '0;
                 esc_n  = '0;
               end else if (danger) begin
                 esc_n = esc_inc;
                 nxt   = (esc_inc >= HOLD_N) ? ALARM : FAN;
               end
        ALARM: if (!Pre) begin
                 nxt    = IDLE;
                 conf_n = '0;
                 esc_n  = '0;
               end
        default: nxt = IDLE;
      endcase
  end
  // outputs registered from the next state so they change together with state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fan   <= 1'b0;
      alarm <= 1'b0;
    end else if (eval) begin
      fan   <= nxt[1];
      alarm <= nxt == ALARM;
    end
  assign state = cur;
endmodule

// File: tb/tb_cabin_alarm_ctrl.sv
// tb_cabin_alarm_ctrl: directed and random stimulus, reference model feeding a scoreboard checked at each state update
module tb_cabin_alarm_ctrl;
  localparam int DIV = 16, TL = 24, REL = 22, CONF = 3, HOLD = 8;
  logic       clk = 0, rst = 1, Ca = 1, Pre = 0;
  logic [4:0] Temp = 0;
  logic       EN, fan, alarm;
  logic [1:0] state;
  int checks = 0, errors = 0, cyc = 0;
  int m = 0, conf = 0, esc = 0;
  logic [3:0] expq[$];
  cabin_alarm_ctrl dut (.clk(clk), .rst(rst), .Temp(Temp), .Ca(Ca), .Pre(Pre),
                        .EN(EN), .fan(fan), .alarm(alarm), .state(state));
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  // reference model: mode 0 idle, 1 watch, 2 fan, 3 alarm; evaluates once per sample period
  initial begin
    bit danger;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        cyc = 0; m = 0; conf = 0; esc = 0;
        expq.delete();
      end else begin
        cyc++;
        if (cyc >= DIV + 2 && cyc % DIV == 2) begin
          danger = !Ca && Pre && Temp >= TL;
          if (Ca) begin
            m = 0; conf = 0; esc = 0;
          end else if (m == 0) begin
            if (danger) begin m = 1; conf = 1; end
          end else if (m == 1) begin
            if (!danger) begin m = 0; conf = 0; end
            else begin
              conf++;
              if (conf == CONF) begin m = 2; conf = 0; esc = 0; end
            end
          end else if (m == 2) begin
            if (!Pre || Temp < REL) begin m = 0; esc = 0; end
            else if (danger) begin
              esc++;
              if (esc == HOLD) m = 3;
            end
          end else if (!Pre) begin
            m = 0; esc = 0;
          end
          expq.push_back({2'(m), m >= 2, m == 3});
        end
      end
    end
  end
  // monitor: the DUT presents a new state two cycles after each EN pulse
  initial begin
    logic [2:0] h;
    h = 0;
    forever begin
      @(negedge clk);
      if (rst) h = 0;
      else begin
        chk("en", EN, (cyc > 0 && cyc % DIV == 0));
        h = {h[1:0], EN};
        if (h[2]) begin
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: state %0d presented, nothing expected", state);
          end else chk("fsm", {state, fan, alarm}, expq.pop_front());
        end
      end
    end
  end
  task automatic cyc_wait(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic evals(int n);
    cyc_wait(DIV * n);
  endtask
  task automatic set(logic c, logic p, logic [4:0] t);
    Ca = c; Pre = p; Temp = t;
  endtask
  task automatic async_reset(string name);
    #2 rst = 1;
    #1 chk(name, {EN, state, fan, alarm}, 0);
    cyc_wait(2);
    rst = 0;
  endtask
  initial begin
    cyc_wait(3);
    chk("reset_out", {EN, state, fan, alarm}, 0);
    rst = 0;
    evals(3);
    set(0, 1, 25); evals(12);
    Temp = 10; evals(2);
    Ca = 1; evals(1);
    set(0, 1, 23); evals(4);
    Temp = 24; evals(2);
    Temp = 20; evals(1);
    Temp = 25; evals(3);
    Temp = 23; evals(3);
    Temp = 22; evals(1);
    Temp = 21; evals(1);
    Temp = 25; evals(12);
    chk("in_alarm", {state, alarm}, 3'b111);
    async_reset("async_rst_alarm");
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 47) == 0) begin
        Temp = 5'($urandom_range(19, 28));
        Pre  = $urandom_range(0, 19) != 0;
        Ca   = $urandom_range(0, 39) == 0;
      end
      if (i == 3000) async_reset("async_rst_mid");
    end
    evals(1);
    #2 chk("queue_drain", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
